// File: rtl/freq_pkg.sv
// Shared types and defaults for the frequency gate sequencer.
package freq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StGate   = 3'd2,
    StSettle = 3'd3,
    StLatch  = 3'd4
  } state_e;

  localparam int unsigned GateBaseDef     = 2500;
  localparam int unsigned NumRangesDef    = 4;
  localparam int unsigned SettleCyclesDef = 4;
  localparam int unsigned LowThreshDef    = 100;
  localparam int unsigned HighThreshDef   = 1000000;

  // Gate length for a decade range: base * 10^rng (2500, 25000, 250000, 2500000 by default).
  function automatic logic [63:0] gate_len(input int unsigned base, input logic [1:0] rng);
    logic [63:0] len;
    len = 64'(base);
    for (int i = 0; i < 3; i++) begin
      if (i < int'(rng)) len = len * 64'd10;
    end
    return len;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter with a zero flag; times both the gate and settle intervals.
module gate_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/freq_gate_sequencer.sv
// Clear / gate / settle / latch sequencer for the edge counter, with decade auto-ranging.
module freq_gate_sequencer
  import freq_pkg::*;
#(
  parameter int unsigned GATE_BASE     = GateBaseDef,
  parameter int unsigned NUM_RANGES    = NumRangesDef,
  parameter int unsigned SETTLE_CYCLES = SettleCyclesDef,
  parameter int unsigned LOW_THRESH    = LowThreshDef,
  parameter int unsigned HIGH_THRESH   = HighThreshDef,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             auto_range,
  input  logic [1:0]       range_sel,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             cnt_clear,
  output logic             cnt_enable,
  output logic [CNT_W-1:0] freq_out,
  output logic [1:0]       range_out,
  output logic             freq_valid,
  output logic             busy
);

  localparam logic [63:0]      MaxGate  = gate_len(GATE_BASE, 2'(NUM_RANGES - 1));
  localparam logic [1:0]       MaxRange = 2'(NUM_RANGES - 1);
  localparam logic [CNT_W-1:0] LowThr   = CNT_W'(LOW_THRESH);
  localparam logic [CNT_W-1:0] HighThr  = CNT_W'(HIGH_THRESH);

  if (MaxGate >= 64'h1_0000_0000 || NUM_RANGES == 0 || NUM_RANGES > 4 ||
      SETTLE_CYCLES == 0 || GATE_BASE == 0) begin : g_param_check
    $error("freq_gate_sequencer: unsupported parameter set");
  end

  state_e      state_q, state_d;
  logic [1:0]  range_q, range_d;   // range of the measurement in flight
  logic [1:0]  auto_q, auto_d;     // range the auto rule picks for the next CLEAR
  logic [1:0]  clear_range;
  logic [31:0] gate_len_sel;
  logic [31:0] timer_val;
  logic        timer_load, timer_dec, timer_zero;
  logic        enter_latch;

  assign clear_range  = auto_range ? auto_q : range_sel;
  assign gate_len_sel = 32'(gate_len(GATE_BASE, clear_range));

  always_comb begin
    state_d     = state_q;
    range_d     = range_q;
    auto_d      = auto_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    timer_val   = '0;
    enter_latch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StClear;
      end
      StClear: begin
        range_d    = clear_range;
        timer_load = 1'b1;
        timer_val  = gate_len_sel - 32'd1;
        state_d    = StGate;
      end
      StGate: begin
        if (timer_zero) begin
          state_d    = StSettle;
          timer_load = 1'b1;
          timer_val  = 32'(SETTLE_CYCLES - 1);
        end else begin
          timer_dec = 1'b1;
        end
      end
      StSettle: begin
        if (timer_zero) begin
          state_d     = StLatch;
          enter_latch = 1'b1;
          // Saturating step toward a gate that keeps the count in the useful window.
          if ((cnt_value < LowThr) && (range_q < MaxRange)) begin
            auto_d = range_q + 2'd1;
          end else if ((cnt_value > HighThr) && (range_q != 2'd0)) begin
            auto_d = range_q - 2'd1;
          end else begin
            auto_d = range_q;
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      StLatch: begin
        state_d = run ? StClear : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  gate_timer #(
    .Width(32)
  ) u_gate_timer (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .dec_i     (timer_dec),
    .zero_o    (timer_zero)
  );

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      range_q    <= 2'd0;
      auto_q     <= 2'd0;
      cnt_clear  <= 1'b0;
      cnt_enable <= 1'b0;
      freq_out   <= '0;
      range_out  <= 2'd0;
      freq_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      range_q    <= range_d;
      auto_q     <= auto_d;
      cnt_clear  <= (state_d == StClear);
      cnt_enable <= (state_d == StGate);
      busy       <= (state_d != StIdle);
      freq_valid <= enter_latch;
      if (enter_latch) begin
        freq_out  <= cnt_value;
        range_out <= range_q;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Scoreboard bench for freq_gate_sequencer with a short gate base to keep runs brief.
module tb_freq_gate_sequencer;

  localparam int unsigned GateBase = 5;
  localparam int unsigned Settle   = 4;
  localparam int unsigned Budget   = 20000;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic        auto_range;
  logic [1:0]  range_sel;
  logic [31:0] cnt_value;
  logic        cnt_clear;
  logic        cnt_enable;
  logic [31:0] freq_out;
  logic [1:0]  range_out;
  logic        freq_valid;
  logic        busy;

  freq_gate_sequencer #(
    .GATE_BASE    (GateBase),
    .NUM_RANGES   (4),
    .SETTLE_CYCLES(Settle),
    .LOW_THRESH   (100),
    .HIGH_THRESH  (1000000),
    .CNT_W        (32)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .run       (run),
    .auto_range(auto_range),
    .range_sel (range_sel),
    .cnt_value (cnt_value),
    .cnt_clear (cnt_clear),
    .cnt_enable(cnt_enable),
    .freq_out  (freq_out),
    .range_out (range_out),
    .freq_valid(freq_valid),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] freq;
    logic [1:0]  rng;
    int unsigned gate;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int clear_cyc = 0;
  int en_run = 0;
  int n_valid = 0;
  int n_clear = 0;
  int clears_seen = 0;
  logic prev_clear = 1'b0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] f, input logic [1:0] r, input int unsigned g);
    exp_t x;
    x.freq = f;
    x.rng  = r;
    x.gate = g;
    sb.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cnt_clear"}, 64'(cnt_clear), 0);
    check({tag, "_cnt_enable"}, 64'(cnt_enable), 0);
    check({tag, "_freq_out"}, 64'(freq_out), 0);
    check({tag, "_range_out"}, 64'(range_out), 0);
    check({tag, "_freq_valid"}, 64'(freq_valid), 0);
    check({tag, "_busy"}, 64'(busy), 0);
  endtask

  task automatic wait_valid(input int target);
    int k;
    k = 0;
    while (n_valid < target && k < Budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (n_valid < target) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got %0d pulses expected %0d", n_valid, target);
    end
  endtask

  task automatic wait_en(input logic level);
    int k;
    k = 0;
    while (cnt_enable !== level && k < Budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (cnt_enable !== level) begin
      total++;
      bad++;
      $display("FAIL wait_enable: got %0b expected %0b", cnt_enable, level);
    end
  endtask

  // Monitor: tracks clear/enable timing and checks every result against the scoreboard.
  always @(negedge clock) begin
    if (!reset_n) begin
      cyc        = 0;
      clear_cyc  = 0;
      en_run     = 0;
      prev_clear = 1'b0;
    end else begin
      cyc++;
      if (cnt_clear) begin
        if (prev_clear) begin
          total++;
          bad++;
          $display("FAIL clear_width: got 2+ cycles expected 1");
        end
        clear_cyc = cyc;
        en_run    = 0;
        n_clear++;
      end
      if (cnt_enable) en_run++;
      if (freq_valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got freq_out=%0d expected no result", freq_out);
        end else begin
          e = sb.pop_front();
          check("freq_out", 64'(freq_out), 64'(e.freq));
          check("range_out", 64'(range_out), 64'(e.rng));
          check("gate_len", 64'(en_run), 64'(e.gate));
          check("latch_latency", 64'(cyc - clear_cyc), 64'(e.gate + Settle + 1));
        end
      end
      prev_clear = cnt_clear;
    end
  end

  initial begin
    reset_n    = 1'b0;
    run        = 1'b0;
    auto_range = 1'b0;
    range_sel  = 2'd0;
    cnt_value  = 32'd0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    #1 reset_n = 1'b1;

    // Manual range 0, single result.
    run       = 1'b1;
    cnt_value = 32'd1234;
    push(32'd1234, 2'd0, 5);
    wait_valid(1);

    // Low count walks the range up and saturates at 3.
    auto_range = 1'b1;
    cnt_value  = 32'd50;
    push(32'd50, 2'd0, 5);
    push(32'd50, 2'd1, 50);
    push(32'd50, 2'd2, 500);
    push(32'd50, 2'd3, 5000);
    push(32'd50, 2'd3, 5000);
    wait_valid(6);

    // High count walks the range down and saturates at 0.
    cnt_value = 32'd2000000;
    push(32'd2000000, 2'd3, 5000);
    push(32'd2000000, 2'd2, 500);
    push(32'd2000000, 2'd1, 50);
    push(32'd2000000, 2'd0, 5);
    push(32'd2000000, 2'd0, 5);
    wait_valid(11);

    // run dropped mid-gate: measurement completes, then idle.
    auto_range = 1'b0;
    range_sel  = 2'd0;
    cnt_value  = 32'd777;
    push(32'd777, 2'd0, 5);
    wait_en(1'b1);
    repeat (2) @(negedge clock);
    #1 run = 1'b0;
    wait_valid(12);
    clears_seen = n_clear;
    repeat (20) @(negedge clock);
    #1;
    check("idle_busy", 64'(busy), 0);
    check("idle_enable", 64'(cnt_enable), 0);
    check("idle_no_clear", 64'(n_clear), 64'(clears_seen));

    // Asynchronous reset in the settle window aborts without a result.
    run       = 1'b1;
    cnt_value = 32'd42;
    wait_en(1'b1);
    wait_en(1'b0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    #20;
    push(32'd42, 2'd0, 5);
    reset_n = 1'b1;
    wait_valid(13);

    // range_sel change during gate only takes effect at the next CLEAR.
    cnt_value = 32'd300;
    push(32'd300, 2'd0, 5);
    push(32'd300, 2'd2, 500);
    wait_en(1'b1);
    range_sel = 2'd2;
    wait_valid(14);
    @(posedge clock);
    #1 run = 1'b0;
    wait_valid(15);
    repeat (5) @(negedge clock);
    #1;
    check("final_busy", 64'(busy), 0);
    check("scoreboard_empty", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_gate_sequencer.md
Name: freq_gate_sequencer

Overview:
Sequences the edge counter that feeds the frequency display path. It clears the counter, opens a precisely timed gate window, and waits a settle interval so in-flight edges drain. It then latches the count as the frequency result. It also picks the gate length from a fixed decade range set, either host-selected or auto-ranged from the previous result. It sits between the board clock domain and the counter, and its result goes to the binary-to-BCD and display-scan logic.

Parameters:
GATE_BASE, 2500, gate length in clock cycles for range 0; range k gate = GATE_BASE*10^k
NUM_RANGES, 4, number of decade ranges (range index 0..NUM_RANGES-1)
SETTLE_CYCLES, 4, idle cycles between gate close and latch
LOW_THRESH, 100, auto-range: count below this value moves to a longer gate
HIGH_THRESH, 1000000, auto-range: count above this value moves to a shorter gate
CNT_W, 32, counter/result width

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
run  in  1  level; high = measure continuously
auto_range  in  1  1 = range chosen by auto-range rule, 0 = range_sel used
range_sel  in  2  manual range index, sampled only in CLEAR
cnt_value  in  CNT_W  current count from edge counter
cnt_clear  out  1  synchronous clear strobe to counter
cnt_enable  out  1  gate to counter; counter counts only while high
freq_out  out  CNT_W  latched count of last completed measurement
range_out  out  2  range index used for freq_out (decimal scale)
freq_valid  out  1  one-cycle pulse when freq_out/range_out update
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt_clear=0, cnt_enable=0, freq_out=0, range_out=0, freq_valid=0, busy=0, internal range=0, gate timer=0. Reset mid-measurement aborts it, with no valid pulse.
- All outputs are registered (Moore). No combinational path from input to output.
- States: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: if run=1 go to CLEAR next cycle, otherwise stay.
- CLEAR (1 cycle, call it cycle 0): cnt_clear=1. Active range is set here: range_sel if auto_range=0, else the internal auto range. Gate timer loads gate_len-1.
- GATE (cycles 1..gate_len): cnt_enable=1 for exactly gate_len cycles. The timer decrements, and the state leaves GATE when the timer is 0. Range 0 gives 2500 cycles; range 3 gives 2,500,000.
- SETTLE (cycles gate_len+1..gate_len+SETTLE_CYCLES): cnt_enable=0, timer counts SETTLE_CYCLES.
- LATCH (cycle gate_len+SETTLE_CYCLES+1): freq_out<=cnt_value, range_out<=active range, freq_valid=1 for this cycle only. The auto range updates as follows:
  - if cnt_value<LOW_THRESH and range<NUM_RANGES-1, then range+1;
  - else if cnt_value>HIGH_THRESH and range>0, then range-1;
  - else unchanged. Range saturates at both ends with no wrap.
  - The next state is CLEAR if run=1, else IDLE.
- run deasserting during CLEAR/GATE/SETTLE does not abort. The measurement completes and latches, then goes to IDLE.
- range_sel and auto_range changes outside CLEAR are ignored until the next CLEAR.
- Gate timer is 32 bits, wide enough for GATE_BASE*10^(NUM_RANGES-1); this product must be below 2^32 (elaboration check).
- cnt_value is treated as unsigned and saturation/overflow is the counter's concern. freq_out is the raw count, and the display scales it by range_out.
- Measurement period equals gate_len+SETTLE_CYCLES+2 cycles, and back-to-back measurements have no IDLE gap.

Decomposition:
- Shared package (freq_pkg): state encoding constants (IDLE=0..LATCH=4), the gate length lookup for range 0..3 (2500, 25000, 250000, 2500000), and LOW_THRESH/HIGH_THRESH defaults.
- One natural sub-module: gate_timer, a loadable down-counter with a zero flag, reused for the GATE and SETTLE intervals.
- The FSM and auto-range logic stay in the top module.

Test Plan:
- Reset, then run=1, auto_range=0, range_sel=0, cnt_value=1234 held -> cnt_clear high 1 cycle, cnt_enable high exactly 2500 cycles, freq_valid at cycle 2505 after CLEAR, freq_out=1234, range_out=0, next CLEAR at cycle 2506.
- auto_range=1, cnt_value=50 each measurement -> range_out steps 0,1,2,3,3 over 5 results with gate 2500/25000/250000/2500000/2500000; saturates at 3.
- auto_range=1, start range 3, cnt_value=2,000,000 -> range decrements 3->2->1->0 and stays 0.
- run dropped mid-GATE (range 0, cycle 1000) -> gate still 2500 cycles, one freq_valid, then IDLE with busy=0 and no further cnt_clear.
- reset_n pulsed low mid-SETTLE -> all outputs to 0 immediately (asynchronously), no freq_valid; after release with run=1 a fresh CLEAR starts.
- range_sel changed 0->2 during GATE -> current measurement keeps range 0; next CLEAR uses range 2 (gate 250000 cycles).
